// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM read streamer.
//   rd_state_e   : sequencer states (idle, issuing reads, draining the buffer)
//   RD_BUF_DEPTH : number of words the output buffer can hold
package ram_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } rd_state_e;

  localparam int unsigned RD_BUF_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO used as the streamer's output buffer.
// Entry 0 is always the head, so dout is a plain register output.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears storage and count)
//   push, din     : write a word (ignored when full unless a pop happens the same cycle)
//   pop           : remove the head word (ignored when empty)
//   dout          : head word
//   full, empty   : occupancy flags
//   count         : number of stored words, 0..2
module stream_fifo2
  import ram_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  localparam logic [1:0] FullCount = 2'(RD_BUF_DEPTH);

  logic [WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign dout    = mem_q[0];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (empty) mem_q[0] <= din;
          else       mem_q[1] <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          mem_q[0] <= mem_q[1];
          count_q  <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            mem_q[0] <= din;
          end else begin
            mem_q[0] <= mem_q[1];
            mem_q[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_rd_streamer.sv
// Read-side sequencer for a single-port synchronous RAM with one-cycle read latency.
// A start command walks a wrapping address range and streams the words out over
// valid/ready with full back-pressure, one word per cycle when the sink is ready.
// Optional feature macro: RD_STREAMER_LAST_EN adds m_last, carried through the buffer.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, base_addr, len : command strobe, first address, word count (0..2**ADDR_WIDTH)
//   busy, done          : command in progress, one-cycle completion pulse
//   ram_addr, ram_dout  : RAM read address (from the pointer), registered RAM read data
//   m_valid, m_data, m_ready : output stream
//   m_last              : final-word marker (RD_STREAMER_LAST_EN only)
module ram_rd_streamer
  import ram_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef RD_STREAMER_LAST_EN
  ,
  output logic                  m_last
`endif
);

`ifdef RD_STREAMER_LAST_EN
  localparam int unsigned FifoWidth = DATA_WIDTH + 1;
`else
  localparam int unsigned FifoWidth = DATA_WIDTH;
`endif

  localparam logic [ADDR_WIDTH:0] CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic                  inflight_q;
  logic                  done_q, done_d;

  logic                  issue;
  logic                  last_issue;
  logic                  pop;
  logic [2:0]            credit;
  logic [FifoWidth-1:0]  fifo_din;
  logic [FifoWidth-1:0]  fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic                  unused_full;

  assign unused_full = fifo_full;

  assign m_valid  = ~fifo_empty;
  assign m_data   = fifo_dout[DATA_WIDTH-1:0];
  assign pop      = m_valid & m_ready;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign ram_addr = ptr_q;

  // Words in flight plus words buffered, net of this cycle's pop, must stay below the
  // buffer depth so a read issued now always has a slot when its data returns.
  assign credit     = 3'(inflight_q) + 3'(fifo_count);
  assign issue      = (state_q == StRun) && (credit < (3'd2 + 3'(pop)));
  assign last_issue = issue && ((issued_q + CntOne) == len_q);

`ifdef RD_STREAMER_LAST_EN
  logic inflight_last_q;

  always_ff @(posedge clk) begin
    if (rst) inflight_last_q <= 1'b0;
    else     inflight_last_q <= last_issue;
  end

  assign fifo_din = {inflight_last_q, ram_dout};
  assign m_last   = m_valid & fifo_dout[DATA_WIDTH];
`else
  assign fifo_din = ram_dout;
`endif

  stream_fifo2 #(
    .WIDTH (FifoWidth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            ptr_d    = base_addr;
            len_d    = len;
            issued_d = '0;
            state_d  = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) begin
          ptr_d    = ptr_q + 1'b1;
          issued_d = issued_q + CntOne;
          if (last_issue) state_d = StDrain;
        end
      end
      StDrain: begin
        // No reads are issued here, so the last buffered word leaving is the final beat.
        if (pop && (fifo_count == 2'd1) && !inflight_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ram_rd_streamer.sv
module tb_ram_rd_streamer;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          m_last;

  logic [DW-1:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] got [64];
  int            got_cyc [64];
  int            got_n;
  int            done_cyc;
  int            stab_err;
  int            last_err;
  bit            timed_out;

  always #5 clk = ~clk;

  // Single-port RAM read port with one registered cycle of latency.
  always @(posedge clk) ram_dout <= mem[ram_addr];

  ram_rd_streamer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
`ifdef RD_STREAMER_LAST_EN
    ,
    .m_last    (m_last)
`endif
  );

`ifndef RD_STREAMER_LAST_EN
  assign m_last = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one sample point after the start edge (cycle 0).
  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: stall 3 cycles on the final beat.
  task automatic run_stream(input int max_cyc, input int mode, input int n_exp,
                            input int extra_start_at);
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    int            stall_cnt;
    prev_stall = 1'b0;
    prev_data  = '0;
    stall_cnt  = 0;
    got_n      = 0;
    done_cyc   = -1;
    stab_err   = 0;
    last_err   = 0;
    timed_out  = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      case (mode)
        1:       m_ready = ((c % 4) == 0) || ((c % 4) == 3);
        2:       m_ready = !((got_n == n_exp - 1) && (stall_cnt < 3));
        default: m_ready = 1'b1;
      endcase
      start = (c == extra_start_at);
      if (start) begin
        base_addr = 4'h8;
        len       = 5'd7;
      end
      if (prev_stall && (!m_valid || (m_data !== prev_data))) stab_err++;
`ifdef RD_STREAMER_LAST_EN
      if (m_valid && (m_last !== (got_n == n_exp - 1))) last_err++;
`endif
      if (m_valid && !m_ready) stall_cnt++;
      if (m_valid && m_ready && (got_n < 64)) begin
        got[got_n]     = m_data;
        got_cyc[got_n] = c;
        got_n++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick();
    end
    start = 1'b0;
    if (done_cyc < 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    base_addr = '0;
    len       = '0;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", m_data); end
    n_cmp++; if (ram_addr !== 4'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", m_last); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'hA5; exp_d[1] = 8'h3C; exp_d[2] = 8'hFF;
    mem[1] = 8'hA5; mem[2] = 8'h3C; mem[3] = 8'hFF;
    m_ready = 1'b1;
    do_start(4'h1, 5'd3);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_hi: got %b want 1", busy); end
    n_cmp++; if (ram_addr !== 4'h1) begin n_bad++; $display("FAIL basic_addr: got %h want 1", ram_addr); end
    run_stream(40, 0, 3, -1);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
    n_cmp++; if (got_n !== 3) begin n_bad++; $display("FAIL basic_count: got %0d want 3", got_n); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got[i] !== exp_d[i] || got_cyc[i] !== i + 2) begin
        n_bad++;
        $display("FAIL basic_beat%0d: got %h@%0d want %h@%0d", i, got[i], got_cyc[i], exp_d[i], i + 2);
      end
    end
    n_cmp++; if (done_cyc !== 5) begin n_bad++; $display("FAIL basic_done_cyc: got %0d want 5", done_cyc); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_lo: got %b want 0", busy); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    mem[14] = 8'h11; mem[15] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
    do_start(4'hE, 5'd4);
    run_stream(40, 0, 4, -1);
    n_cmp++; if (got_n !== 4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_d[i]) begin n_bad++; $display("FAIL wrap_beat%0d: got %h want %h", i, got[i], exp_d[i]); end
    end
    n_cmp++; if (done_cyc !== 6) begin n_bad++; $display("FAIL wrap_done_cyc: got %0d want 6", done_cyc); end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] exp_d [16];
    int            data_err;
    for (int i = 0; i < 16; i++) begin
      exp_d[i] = 8'((i * 17) ^ 8'h5A);
      mem[i]   = exp_d[i];
    end
    do_start(4'h0, 5'd16);
    run_stream(300, 1, 16, -1);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: got %b want 0", timed_out); end
    n_cmp++; if (got_n !== 16) begin n_bad++; $display("FAIL bp_count: got %0d want 16", got_n); end
    data_err = 0;
    for (int i = 0; i < 16; i++) begin
      if (got[i] !== exp_d[i]) begin
        data_err++;
        $display("FAIL bp_beat%0d: got %h want %h", i, got[i], exp_d[i]);
      end
    end
    n_cmp++; if (data_err !== 0) begin n_bad++; $display("FAIL bp_data: got %0d bad beats want 0", data_err); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d stall violations want 0", stab_err); end
    tick();
  endtask

  task automatic test_len0_and_busy_start();
    do_start(4'h5, 5'd0);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL len0_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++; $display("FAIL len0_idle: got busy=%b valid=%b want 0 0", busy, m_valid);
    end
    tick();
    n_cmp++; if (done !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++; $display("FAIL len0_after: got done=%b valid=%b want 0 0", done, m_valid);
    end
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hC0 + i);
    do_start(4'h0, 5'd4);
    run_stream(40, 0, 4, 1);
    n_cmp++; if (got_n !== 4) begin n_bad++; $display("FAIL busy_start_count: got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== 8'(8'hC0 + i)) begin n_bad++; $display("FAIL busy_start_beat%0d: got %h want %h", i, got[i], 8'(8'hC0 + i)); end
    end
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++; $display("FAIL busy_start_ignored: got busy=%b valid=%b want 0 0", busy, m_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h20 + i);
    m_ready = 1'b1;
    do_start(4'h0, 5'd8);
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_state: got valid=%b busy=%b done=%b want 0 0 0", m_valid, busy, done);
    end
    n_cmp++; if (ram_addr !== 4'h0) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 0", ram_addr); end
    rst = 1'b0;
    tick();
    do_start(4'h3, 5'd2);
    run_stream(40, 0, 2, -1);
    n_cmp++; if (got_n !== 2 || got[0] !== 8'h23 || got[1] !== 8'h24) begin
      n_bad++; $display("FAIL rst_mid_restart: got n=%0d %h %h want n=2 23 24", got_n, got[0], got[1]);
    end
    n_cmp++; if (done_cyc !== 4) begin n_bad++; $display("FAIL rst_mid_done_cyc: got %0d want 4", done_cyc); end
    tick();
  endtask

`ifdef RD_STREAMER_LAST_EN
  task automatic test_last();
    mem[5] = 8'h51; mem[6] = 8'h62; mem[7] = 8'h73;
    do_start(4'h5, 5'd3);
    run_stream(40, 2, 3, -1);
    n_cmp++; if (got_n !== 3 || got[2] !== 8'h73) begin
      n_bad++; $display("FAIL last_beats: got n=%0d last=%h want n=3 last=73", got_n, got[2]);
    end
    n_cmp++; if (last_err !== 0) begin n_bad++; $display("FAIL last_flag: got %0d bad samples want 0", last_err); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL last_stable: got %0d want 0", stab_err); end
    n_cmp++; if (done_cyc !== 8) begin n_bad++; $display("FAIL last_done_cyc: got %0d want 8", done_cyc); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL last_clear: got %b want 0", m_last); end
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_back_pressure();
    test_len0_and_busy_start();
    test_reset_mid_burst();
`ifdef RD_STREAMER_LAST_EN
    test_last();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
